// File: rtl/matrix_pkg.sv
// Shared FSM state type, default element width and sizing helper for matrix_add_sequencer.
package matrix_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } seq_state_e;

  localparam int unsigned DefaultDataWidth = 16;

  // Element counter width; a single-element matrix still gets a 1-bit counter.
  function automatic int unsigned ctr_width(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/elem_adder.sv
// One element adder shared by the sequencer: s = a + b, wrapping by default,
// signed-saturating when MATRIX_SEQ_SAT_EN is defined.
module elem_adder
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] s
);

`ifdef MATRIX_SEQ_SAT_EN
  localparam int unsigned Msb = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] SatMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SatMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] raw;
  logic                  ovf;

  assign raw = a + b;
  // Overflow only when both operands share a sign and the sum's sign differs.
  assign ovf = (a[Msb] == b[Msb]) && (raw[Msb] != a[Msb]);

  always_comb begin
    s = raw;
    if (ovf) begin
      s = a[Msb] ? SatMin : SatMax;
    end
  end
`else
  assign s = a + b;
`endif

endmodule

// File: rtl/matrix_add_sequencer.sv
// Element-serial matrix adder: latches A and B, adds one element per cycle through a single
// elem_adder, then holds the result until handshaken. Saturation via MATRIX_SEQ_SAT_EN.
module matrix_add_sequencer
  import matrix_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned M          = 2,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*M*DATA_WIDTH-1:0] a,
  input  logic [N*M*DATA_WIDTH-1:0] b,
  input  logic                      abort,
  output logic [N*M*DATA_WIDTH-1:0] res,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int unsigned NumElem = N * M;
  localparam int unsigned KW      = ctr_width(NumElem);
  localparam int unsigned VecW    = NumElem * DATA_WIDTH;
  localparam logic [KW-1:0] LastK = KW'(NumElem - 1);

  seq_state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [VecW-1:0] a_q, b_q;

  logic [DATA_WIDTH-1:0] res_q [NumElem];
  logic [DATA_WIDTH-1:0] a_el  [NumElem];
  logic [DATA_WIDTH-1:0] b_el  [NumElem];
  logic [DATA_WIDTH-1:0] op_a, op_b, sum;

  logic accept;
  logic step;
  logic last;

  // Row-major, MSB-first: element 0 sits in the top DATA_WIDTH bits.
  for (genvar e = 0; e < NumElem; e++) begin : g_elem
    assign a_el[e] = a_q[(NumElem-e)*DATA_WIDTH-1 -: DATA_WIDTH];
    assign b_el[e] = b_q[(NumElem-e)*DATA_WIDTH-1 -: DATA_WIDTH];
    assign res[(NumElem-e)*DATA_WIDTH-1 -: DATA_WIDTH] = res_q[e];
  end

  assign op_a = a_el[k_q];
  assign op_b = b_el[k_q];
  assign last = (k_q == LastK);

  elem_adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_elem_adder (
    .a(op_a),
    .b(op_b),
    .s(sum)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next state and handshake outputs; abort outranks completion and out_ready.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else begin
          step = 1'b1;
          if (last) begin
            k_d     = '0;
            state_d = StDone;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (abort || out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Operand capture and element-serial result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      for (int unsigned e = 0; e < NumElem; e++) begin
        res_q[e] <= '0;
      end
    end else begin
      if (accept) begin
        a_q <= a;
        b_q <= b;
      end
      if (step) begin
        res_q[k_q] <= sum;
      end
    end
  end

endmodule

// File: tb/tb_matrix_add_sequencer.sv
// Self-checking bench for matrix_add_sequencer (N=2, M=2, DATA_WIDTH=16); honours MATRIX_SEQ_SAT_EN.
module tb_matrix_add_sequencer;

  localparam int unsigned NumElem = 4;
  localparam int unsigned Dw      = 16;
  localparam int unsigned VecW    = NumElem * Dw;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [VecW-1:0] a_in;
  logic [VecW-1:0] b_in;
  logic            abort;
  logic [VecW-1:0] res_out;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  int n_vec;
  int n_err;

  typedef struct {
    string           name;
    logic [VecW-1:0] a;
    logic [VecW-1:0] b;
    logic [VecW-1:0] exp;
  } vec_t;

  vec_t vecs[4];
  logic [Dw-1:0] corner[4];

  matrix_add_sequencer #(
    .N(2),
    .M(2),
    .DATA_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a_in),
    .b(b_in),
    .abort(abort),
    .res(res_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [VecW-1:0] act, input logic [VecW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: each element summed independently as an integer, then wrapped or clamped.
  function automatic logic [VecW-1:0] model_sum(input logic [VecW-1:0] x, input logic [VecW-1:0] y);
    logic [VecW-1:0] r;
    logic [Dw-1:0]   ea, eb;
    int              s;
    int              sh;
    r = '0;
    for (int k = 0; k < NumElem; k++) begin
      sh = (NumElem - 1 - k) * Dw;
      ea = x[sh +: Dw];
      eb = y[sh +: Dw];
`ifdef MATRIX_SEQ_SAT_EN
      s = int'($signed(ea)) + int'($signed(eb));
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`else
      s = (int'(ea) + int'(eb)) % 65536;
`endif
      r[sh +: Dw] = s[15:0];
    end
    return r;
  endfunction

  function automatic logic [VecW-1:0] rand_vec();
    logic [VecW-1:0] v;
    for (int k = 0; k < NumElem; k++) begin
      if ($urandom_range(0, 2) == 0) v[k*Dw +: Dw] = corner[$urandom_range(0, 3)];
      else v[k*Dw +: Dw] = 16'($urandom);
    end
    return v;
  endfunction

  task automatic wait_ready();
    int c;
    c = 0;
    while (!in_ready && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("in_ready_wait", VecW'(in_ready), VecW'(1));
  endtask

  // Returns at #1 after the accepting edge (cycle 0 of the job).
  task automatic start_job(input logic [VecW-1:0] x, input logic [VecW-1:0] y);
    wait_ready();
    a_in     = x;
    b_in     = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input logic [VecW-1:0] exp);
    int c;
    c = 0;
    while (!out_valid && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({nm, "_latency"}, VecW'(c), VecW'(4));
    check({nm, "_res"}, res_out, exp);
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({nm, "_pulse"}, VecW'(out_valid), VecW'(0));
    end
  endtask

  task automatic run_job(input string nm, input logic [VecW-1:0] x, input logic [VecW-1:0] y,
                         input logic [VecW-1:0] exp);
    out_ready = 1'b1;
    start_job(x, y);
    check({nm, "_busy"}, VecW'(busy), VecW'(1));
    wait_done(nm, exp);
  endtask

  initial begin
    logic [VecW-1:0] x, y, hold;
    int              seen;
    int              c;

    n_vec     = 0;
    n_err     = 0;
    corner[0] = 16'h7FFF;
    corner[1] = 16'h8000;
    corner[2] = 16'hFFFF;
    corner[3] = 16'h0001;

    vecs[0] = '{"basic", 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040,
                64'h0011_0022_0033_0044};
    vecs[1] = '{"mixed", 64'h1234_5678_0ABC_0DEF, 64'h1111_2222_0333_0444,
                64'h2345_789A_0DEF_1233};
`ifdef MATRIX_SEQ_SAT_EN
    vecs[2] = '{"sat_a", 64'h7FFF_8000_0001_FFFF, 64'h0001_FFFF_0002_FFFF,
                64'h7FFF_8000_0003_FFFE};
    vecs[3] = '{"sat_b", 64'h7FFF_8000_4000_C000, 64'h7FFF_8000_4000_C000,
                64'h7FFF_8000_7FFF_8000};
`else
    vecs[2] = '{"wrap_a", 64'hFFFF_1234_8000_7FFF, 64'h0002_0001_8000_0001,
                64'h0001_1235_0000_8000};
    vecs[3] = '{"wrap_b", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0001_0001_0001_0001,
                64'h0000_0000_0000_0000};
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    #12;
    check("rst_out_valid", VecW'(out_valid), VecW'(0));
    check("rst_busy", VecW'(busy), VecW'(0));
    check("rst_res", res_out, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", VecW'(in_ready), VecW'(1));

    for (int i = 0; i < 4; i++) begin
      run_job(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    for (int i = 0; i < 16; i++) begin
      x = rand_vec();
      y = rand_vec();
      run_job("random", x, y, model_sum(x, y));
    end

    // Backpressure: result held for 10 cycles, second job waits for the handshake.
    x = rand_vec();
    y = rand_vec();
    out_ready = 1'b0;
    start_job(x, y);
    wait_done("bp_first", model_sum(x, y));
    hold     = model_sum(x, y);
    a_in     = 64'h0001_0002_0003_0004;
    b_in     = 64'h0010_0020_0030_0040;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", VecW'(out_valid), VecW'(1));
      check("bp_res_stable", res_out, hold);
      check("bp_in_ready", VecW'(in_ready), VecW'(0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_handshake_idle", VecW'(busy), VecW'(0));
    check("bp_handshake_valid", VecW'(out_valid), VecW'(0));
    check("bp_ready_after", VecW'(in_ready), VecW'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_second_accept", VecW'(busy), VecW'(1));
    wait_done("bp_second", 64'h0011_0022_0033_0044);

    // Abort two cycles after accept.
    x = rand_vec();
    y = rand_vec();
    start_job(x, y);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", VecW'(busy), VecW'(0));
    check("abort_in_ready", VecW'(in_ready), VecW'(1));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1;
      @(posedge clk);
      #1;
    end
    check("abort_no_valid", VecW'(seen), VecW'(0));
    x = rand_vec();
    y = rand_vec();
    run_job("after_abort", x, y, model_sum(x, y));

    // Abort in DONE wins over out_ready.
    x = rand_vec();
    y = rand_vec();
    out_ready = 1'b0;
    start_job(x, y);
    wait_done("done_abort_pre", model_sum(x, y));
    abort     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("done_abort_valid", VecW'(out_valid), VecW'(0));
    check("done_abort_ready", VecW'(in_ready), VecW'(1));

    // Abort in IDLE is ignored: the job is still accepted.
    x        = rand_vec();
    y        = rand_vec();
    a_in     = x;
    b_in     = y;
    abort    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    check("idle_abort_busy", VecW'(busy), VecW'(1));
    wait_done("idle_abort", model_sum(x, y));

    // Reset while RUN with k=2.
    x = rand_vec();
    y = rand_vec();
    start_job(x, y);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", VecW'(busy), VecW'(0));
    check("mid_rst_valid", VecW'(out_valid), VecW'(0));
    check("mid_rst_res", res_out, '0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", VecW'(in_ready), VecW'(1));
    seen = 0;
    c    = 0;
    while (c < 8) begin
      if (out_valid) seen = 1;
      @(posedge clk);
      #1;
      c++;
    end
    check("mid_rst_no_valid", VecW'(seen), VecW'(0));
    x = rand_vec();
    y = rand_vec();
    run_job("after_rst", x, y, model_sum(x, y));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_add_sequencer.md
MATRIX_ADD_SEQUENCER -- requirements
Module: matrix_add_sequencer

Interface
REQ-001 SHALL have parameter N, default 2, matrix rows.
REQ-002 SHALL have parameter M, default 2, matrix columns.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, bits per element.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, operand pair a/b presented.
REQ-007 SHALL have port in_ready, output, 1, sequencer can accept operands.
REQ-008 SHALL have port a, input, N*M*DATA_WIDTH, first matrix.
REQ-009 SHALL have port b, input, N*M*DATA_WIDTH, second matrix.
REQ-010 SHALL have port abort, input, 1, synchronous cancel of current job.
REQ-011 SHALL have port res, output, N*M*DATA_WIDTH, result matrix.
REQ-012 SHALL have port out_valid, output, 1, res holds a completed sum.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts res.
REQ-014 SHALL have port busy, output, 1, high in RUN state.

Function
REQ-015 SHALL pack elements row-major, MSB-first: element k=i*M+j occupies bits [(N*M-k)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL assert in_ready only in IDLE; accept on the edge where in_valid && in_ready, latching a and b, clearing counter k to 0, going to RUN.
REQ-018 SHALL in RUN compute exactly one element per cycle through one shared element adder: res element k <= a_k + b_k, then k <= k+1.
REQ-019 SHALL go RUN->DONE on the edge processing k = N*M-1; out_valid first high N*M cycles after the accepting edge.
REQ-020 SHALL hold res and out_valid stable in DONE until out_valid && out_ready; on that edge go DONE->IDLE.
REQ-021 SHALL, with abort high in RUN or DONE, go to IDLE next edge, drop out_valid, leave res contents unspecified; abort in IDLE is ignored.
REQ-022 SHALL give abort priority over completion and over out_ready on the same edge.
REQ-023 SHALL, by default, add modulo 2^DATA_WIDTH (carry discarded, two's-complement wrap).
REQ-024 SHALL not accept new operands in the cycle DONE->IDLE occurs (in_ready rises the following cycle).
REQ-025 SHALL size counter k as $clog2(N*M) bits, minimum 1.

Reset
REQ-026 SHALL on rst_n low immediately force IDLE, in_ready=1 after release, out_valid=0, busy=0, res=0, k=0.
REQ-027 SHALL abandon any in-flight job when reset asserts mid-RUN or mid-DONE; no partial result is ever flagged valid.

Configuration
REQ-028 SHALL, with macro MATRIX_SEQ_SAT_EN defined, perform signed saturating addition: positive overflow yields 2^(DATA_WIDTH-1)-1, negative overflow yields -2^(DATA_WIDTH-1).
REQ-029 SHALL, without MATRIX_SEQ_SAT_EN, use wrap-around addition per REQ-023 with no saturation logic present.

Structure
REQ-030 SHALL place FSM state enum and default DATA_WIDTH constant in shared package matrix_pkg.
REQ-031 SHALL instantiate exactly one sub-module elem_adder (DATA_WIDTH-wide A, B in; S out; saturation per macro).

Verification (N=2, M=2, DATA_WIDTH=16)
REQ-032 SHALL check: a=0x0001_0002_0003_0004, b=0x0010_0020_0030_0040, out_ready=1 -> res=0x0011_0022_0033_0044, out_valid high 4 cycles after accept, one cycle long.
REQ-033 SHALL check wrap (no macro): a elem0=0xFFFF, b elem0=0x0002 -> res elem0=0x0001; with MATRIX_SEQ_SAT_EN a=0x7FFF,b=0x0001 -> 0x7FFF and a=0x8000,b=0xFFFF -> 0x8000.
REQ-034 SHALL check backpressure: out_ready=0 for 10 cycles in DONE -> res/out_valid stable, in_ready=0, second in_valid not accepted until after handshake.
REQ-035 SHALL check abort asserted 2 cycles after accept -> IDLE next edge, out_valid never rises, next job result correct.
REQ-036 SHALL check rst_n low during RUN (k=2) -> outputs at reset values asynchronously; after release a fresh job completes correctly.
